// File: rtl/gecko_pkg.sv
// Shared types for the gecko register scoreboard: per-register status
// encoding and the drain sequencing FSM state.
package gecko_pkg;

   localparam int GECKO_NUM_REGS = 32;
   localparam int GECKO_REG_AW   = 5;

   typedef enum logic [1:0] {
      GECKO_REG_STATUS_VALID   = 2'd0,
      GECKO_REG_STATUS_PARTIAL = 2'd1,
      GECKO_REG_STATUS_FULL    = 2'd2
   } gecko_reg_status_t;

   typedef enum logic [1:0] {
      GECKO_SB_RUN   = 2'd0,
      GECKO_SB_DRAIN = 2'd1,
      GECKO_SB_IDLE  = 2'd2
   } gecko_sb_state_t;

   // Counter width needed to hold 0..max_inflight.
   function automatic int gecko_cnt_width(input int max_inflight);
      return $clog2(max_inflight + 1);
   endfunction

endpackage

// File: rtl/gecko_reg_counter.sv
// One in-flight write counter for a single architectural register.
// inc and dec in the same cycle cancel; dec at zero holds zero and
// flags underflow for that cycle; inc at MAX_INFLIGHT saturates.
module gecko_reg_counter
   import gecko_pkg::*;
#(
   parameter int MAX_INFLIGHT = 3,
   localparam int CW = gecko_cnt_width(MAX_INFLIGHT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   output logic [CW-1:0]     count,
   output gecko_reg_status_t status,
   output logic              underflow
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

   // Count register: net +1 / -1 only when exactly one of inc/dec is set.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && (count != MAX_C)) begin
         count <= count + CW'(1);
      end else if (dec && !inc && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   // Status decode from the registered count.
   always_comb begin
      status = GECKO_REG_STATUS_PARTIAL;
      if (count == '0) begin
         status = GECKO_REG_STATUS_VALID;
      end else if (count == MAX_C) begin
         status = GECKO_REG_STATUS_FULL;
      end
   end

   assign underflow = dec && !inc && (count == '0);

endmodule

// File: rtl/gecko_reg_scoreboard.sv
// Register write scoreboard for gecko decode/writeback.
// Issue handshake: an issue transfers on a rising edge where
// issue_valid && issue_ready; issue_ready never looks at issue_valid.
// Retires have no handshake and are always taken.
module gecko_reg_scoreboard
   import gecko_pkg::*;
#(
   parameter int MAX_INFLIGHT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rd,
   output logic              issue_ready,
   input  logic              retire_valid,
   input  logic [4:0]        retire_rd,
   input  logic [4:0]        rs1_addr,
   input  logic [4:0]        rs2_addr,
   input  logic [4:0]        rd_addr,
   output gecko_reg_status_t rs1_status,
   output gecko_reg_status_t rs2_status,
   output gecko_reg_status_t rd_status,
   input  logic              drain_req,
   output logic              drained,
   output logic              error,
   output gecko_sb_state_t   sb_state
);

   localparam int CW = gecko_cnt_width(MAX_INFLIGHT);

   gecko_sb_state_t   state, state_next;
   gecko_reg_status_t status_arr [GECKO_NUM_REGS];
   logic [CW-1:0]     cnt        [1:GECKO_NUM_REGS-1];
   logic [GECKO_NUM_REGS-1:1] inc_vec, dec_vec, uflow_vec, zero_vec;
   logic              issue_fire;
   logic              all_zero;

   assign issue_fire    = issue_valid && issue_ready;
   assign status_arr[0] = GECKO_REG_STATUS_VALID;

   genvar r;
   generate
      for (r = 1; r < GECKO_NUM_REGS; r++) begin : g_reg
         assign inc_vec[r]  = issue_fire && (issue_rd == GECKO_REG_AW'(r));
         assign dec_vec[r]  = retire_valid && (retire_rd == GECKO_REG_AW'(r));
         assign zero_vec[r] = (cnt[r] == '0);

         gecko_reg_counter #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[r]),
            .dec       (dec_vec[r]),
            .count     (cnt[r]),
            .status    (status_arr[r]),
            .underflow (uflow_vec[r])
         );
      end
   endgenerate

   assign all_zero = &zero_vec;

   // State register; drained is registered alongside so it tracks IDLE exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= GECKO_SB_RUN;
         drained <= 1'b0;
      end else begin
         state   <= state_next;
         drained <= (state_next == GECKO_SB_IDLE);
      end
   end

   // Next-state: drain waits for every counter to read zero; once started it always completes.
   always_comb begin
      state_next = state;
      case (state)
         GECKO_SB_RUN:   if (drain_req) state_next = GECKO_SB_DRAIN;
         GECKO_SB_DRAIN: if (all_zero)  state_next = GECKO_SB_IDLE;
         GECKO_SB_IDLE:  if (!drain_req) state_next = GECKO_SB_RUN;
         default:        state_next = GECKO_SB_RUN;
      endcase
   end

   // Outputs: issue only in RUN and only when the target register is not FULL.
   always_comb begin
      issue_ready = (state == GECKO_SB_RUN) &&
                    ((issue_rd == '0) || (status_arr[issue_rd] != GECKO_REG_STATUS_FULL));
      sb_state    = state;
   end

   // Sticky underflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         error <= 1'b0;
      end else if (|uflow_vec) begin
         error <= 1'b1;
      end
   end

   assign rs1_status = status_arr[rs1_addr];
   assign rs2_status = status_arr[rs2_addr];
   assign rd_status  = status_arr[rd_addr];

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// Bench for gecko_reg_scoreboard: directed table, hand-written drain/reset
// sequences, then randomized traffic against a counting reference model.
module tb_gecko_reg_scoreboard;
   import gecko_pkg::*;

   localparam int MAXI = 3;

   logic clk, rst;
   logic issue_valid, retire_valid, drain_req;
   logic [4:0] issue_rd, retire_rd, rs1_addr, rs2_addr, rd_addr;
   logic issue_ready, drained, error;
   gecko_reg_status_t rs1_status, rs2_status, rd_status;
   gecko_sb_state_t sb_state;

   int n_vec = 0;
   int n_bad = 0;

   gecko_reg_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .retire_valid(retire_valid), .retire_rd(retire_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1_status(rs1_status), .rs2_status(rs2_status), .rd_status(rd_status),
      .drain_req(drain_req), .drained(drained), .error(error),
      .sb_state(sb_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain per-register counts plus drain mode (0 run, 1 draining, 2 drained)
   int cnt_m [32];
   int mode_m;
   bit err_m;

   function automatic int model_status(input int r);
      if (r == 0 || cnt_m[r] == 0) return 0;
      if (cnt_m[r] == MAXI) return 2;
      return 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) cnt_m[i] = 0;
      mode_m = 0;
      err_m  = 1'b0;
   endtask

   // Driver tasks
   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      issue_valid = 1'b0; issue_rd = '0;
      retire_valid = 1'b0; retire_rd = '0;
      drain_req = 1'b0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic cyc_issue(input int rd);
      issue_valid = 1'b1; issue_rd = 5'(rd);
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic cyc_retire(input int rd);
      retire_valid = 1'b1; retire_rd = 5'(rd);
      tick();
      retire_valid = 1'b0;
   endtask

   // Directed vector table: inputs for one cycle and the outputs expected
   // before the edge of that cycle.
   typedef struct {
      logic       iv;
      logic [4:0] ird;
      logic       rv;
      logic [4:0] rrd;
      logic [4:0] q;
      int         exp_ready;
      int         exp_st;
      int         exp_err;
   } vec_t;

   vec_t tbl [13];

   initial begin
      rst = 1'b1;
      idle_in();
      tick();
      tick();
      rst = 1'b0;

      // Reset state: every register VALID
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i); rs2_addr = 5'((i + 11) % 32); rd_addr = 5'((i + 22) % 32);
         #1;
         chk($sformatf("rst_rs1_x%0d", i), int'(rs1_status), 0);
         chk($sformatf("rst_rs2_x%0d", (i + 11) % 32), int'(rs2_status), 0);
         chk($sformatf("rst_rd_x%0d", (i + 22) % 32), int'(rd_status), 0);
      end
      issue_rd = 5'd17;
      #1;
      chk("rst_ready", int'(issue_ready), 1);
      chk("rst_drained", int'(drained), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_state", int'(sb_state == GECKO_SB_RUN), 1);
      tick();

      //          iv    ird   rv    rrd   q     rdy st err
      tbl[0]  = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 1, 0, 0};
      tbl[1]  = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 1, 1, 0};
      tbl[2]  = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 1, 1, 0};
      tbl[3]  = '{1'b0, 5'd5, 1'b0, 5'd0, 5'd5, 0, 2, 0};
      tbl[4]  = '{1'b0, 5'd6, 1'b0, 5'd0, 5'd5, 1, 2, 0};
      tbl[5]  = '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 0, 2, 0};
      tbl[6]  = '{1'b0, 5'd5, 1'b0, 5'd0, 5'd5, 1, 1, 0};
      tbl[7]  = '{1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 1, 0, 0};
      tbl[8]  = '{1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 1, 1, 0};
      tbl[9]  = '{1'b0, 5'd0, 1'b1, 5'd9, 5'd7, 1, 1, 0};
      tbl[10] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd9, 1, 0, 1};
      tbl[11] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1, 0, 1};
      tbl[12] = '{1'b0, 5'd5, 1'b0, 5'd0, 5'd9, 1, 0, 1};

      for (int i = 0; i < 13; i++) begin
         issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
         retire_valid = tbl[i].rv; retire_rd = tbl[i].rrd;
         rs1_addr = tbl[i].q; rs2_addr = tbl[i].q; rd_addr = tbl[i].q;
         #1;
         chk($sformatf("tbl%0d_ready", i), int'(issue_ready), tbl[i].exp_ready);
         chk($sformatf("tbl%0d_rs1", i), int'(rs1_status), tbl[i].exp_st);
         chk($sformatf("tbl%0d_rd", i), int'(rd_status), tbl[i].exp_st);
         chk($sformatf("tbl%0d_err", i), int'(error), tbl[i].exp_err);
         chk($sformatf("tbl%0d_drained", i), int'(drained), 0);
         tick();
      end
      idle_in();

      // Drain with outstanding writes: x3=1, x4=2
      do_reset();
      cyc_issue(3);
      cyc_issue(4);
      cyc_issue(4);
      drain_req = 1'b1; issue_rd = 5'd8;
      #1;
      chk("drn_ready_req_cycle", int'(issue_ready), 1);
      tick();
      chk("drn_ready_blocked", int'(issue_ready), 0);
      chk("drn_state_drain", int'(sb_state == GECKO_SB_DRAIN), 1);
      cyc_retire(3);
      cyc_retire(4);
      cyc_retire(4);
      rs1_addr = 5'd4; rs2_addr = 5'd3;
      #1;
      chk("drn_n1_drained", int'(drained), 0);
      chk("drn_n1_x4", int'(rs1_status), 0);
      chk("drn_n1_x3", int'(rs2_status), 0);
      tick();
      chk("drn_n2_drained", int'(drained), 1);
      chk("drn_n2_ready", int'(issue_ready), 0);
      drain_req = 1'b0;
      tick();
      chk("drn_run_ready", int'(issue_ready), 1);
      chk("drn_run_drained", int'(drained), 0);

      // Empty drain, request dropped while in DRAIN
      drain_req = 1'b1;
      tick();
      chk("edrn_c1_drained", int'(drained), 0);
      chk("edrn_c1_state", int'(sb_state == GECKO_SB_DRAIN), 1);
      drain_req = 1'b0;
      tick();
      chk("edrn_c2_drained", int'(drained), 1);
      tick();
      chk("edrn_c3_drained", int'(drained), 0);
      chk("edrn_c3_ready", int'(issue_ready), 1);

      // Reset during DRAIN with x10 FULL and error set
      cyc_retire(11);
      cyc_issue(10);
      cyc_issue(10);
      cyc_issue(10);
      drain_req = 1'b1;
      tick();
      rs1_addr = 5'd10;
      #1;
      chk("rstd_pre_state", int'(sb_state == GECKO_SB_DRAIN), 1);
      chk("rstd_pre_x10", int'(rs1_status), 2);
      chk("rstd_pre_err", int'(error), 1);
      rst = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd10;
      retire_valid = 1'b1; retire_rd = 5'd12;
      tick();
      rst = 1'b0;
      issue_valid = 1'b0; retire_valid = 1'b0; drain_req = 1'b0;
      issue_rd = 5'd10;
      #1;
      chk("rstd_state", int'(sb_state == GECKO_SB_RUN), 1);
      chk("rstd_x10", int'(rs1_status), 0);
      chk("rstd_drained", int'(drained), 0);
      chk("rstd_err", int'(error), 0);
      chk("rstd_ready", int'(issue_ready), 1);

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int q_live [$];
         int ird_i, rrd_i, exp_rdy;
         bit fire, allz, do_rst;

         if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
         do_rst = ($urandom_range(0, 299) == 0);
         ird_i = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
         for (int r = 1; r < 8; r++) if (cnt_m[r] > 0) q_live.push_back(r);
         if (q_live.size() > 0 && $urandom_range(0, 19) != 0)
            rrd_i = q_live[$urandom_range(0, q_live.size() - 1)];
         else
            rrd_i = $urandom_range(0, 7);

         rst = do_rst;
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd = 5'(ird_i);
         retire_valid = ($urandom_range(0, 2) != 0);
         retire_rd = 5'(rrd_i);
         rs1_addr = 5'($urandom_range(0, 7));
         rs2_addr = 5'($urandom_range(0, 7));
         rd_addr  = 5'($urandom_range(0, 31));
         #1;

         exp_rdy = (mode_m == 0 && (ird_i == 0 || cnt_m[ird_i] < MAXI)) ? 1 : 0;
         chk("rnd_ready", int'(issue_ready), exp_rdy);
         chk("rnd_rs1", int'(rs1_status), model_status(int'(rs1_addr)));
         chk("rnd_rs2", int'(rs2_status), model_status(int'(rs2_addr)));
         chk("rnd_rd", int'(rd_status), model_status(int'(rd_addr)));
         chk("rnd_drained", int'(drained), (mode_m == 2) ? 1 : 0);
         chk("rnd_err", int'(error), int'(err_m));

         // Apply the cycle's effect to the model
         if (do_rst) begin
            model_reset();
         end else begin
            fire = issue_valid && (exp_rdy == 1);
            allz = 1'b1;
            for (int r = 1; r < 32; r++) if (cnt_m[r] != 0) allz = 1'b0;
            case (mode_m)
               0: if (drain_req) mode_m = 1;
               1: if (allz) mode_m = 2;
               default: if (!drain_req) mode_m = 0;
            endcase
            if (!(fire && retire_valid && ird_i == rrd_i)) begin
               if (fire && ird_i != 0) cnt_m[ird_i]++;
               if (retire_valid && rrd_i != 0) begin
                  if (cnt_m[rrd_i] > 0) cnt_m[rrd_i]--;
                  else err_m = 1'b1;
               end
            end
         end
         tick();
      end
      rst = 1'b0;
      idle_in();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/gecko_reg_scoreboard.md
# gecko_reg_scoreboard

Tracks outstanding register writes for the gecko decode stage with a per-register in-flight counter. Decode issues an instruction writing rd and writeback retires it; per-register status (VALID / PARTIAL / FULL) feeds the decode readability and writeability checks. It also sequences a drain on request: issue is blocked until every outstanding write has retired, then drained is reported. Sits between gecko decode (issue and query side) and gecko writeback (retire side).

## Interface

Parameters:
- MAX_INFLIGHT, 3: maximum outstanding writes per register. Legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  decode wants to issue a write to issue_rd
- issue_rd  in  5  destination register of the issuing instruction
- issue_ready  out  1  issue is accepted when issue_valid && issue_ready
- retire_valid  in  1  writeback completed a write to retire_rd; always accepted
- retire_rd  in  5  register being retired
- rs1_addr, rs2_addr, rd_addr  in  5 each  query addresses
- rs1_status, rs2_status, rd_status  out  gecko_reg_status_t each  status of the queried registers
- drain_req  in  1  request to block issue and empty the scoreboard
- drained  out  1  scoreboard empty and issue blocked
- error  out  1  sticky flag: retire to a register with zero count

## Operation

- Each of x1..x31 has a counter cnt[r] of width $clog2(MAX_INFLIGHT+1). x0 has no counter; its status is always VALID.
- Status encoding:
  - cnt==0: VALID
  - 0<cnt<MAX_INFLIGHT: PARTIAL
  - cnt==MAX_INFLIGHT: FULL
- Query outputs are combinational from registered counters. A same-cycle issue or retire is not visible until the next cycle.
- issue_ready = (state==RUN) && (issue_rd==0 || status[issue_rd]!=FULL). It depends on issue_rd but never on issue_valid.
- Issue fire to rd!=0 increments cnt[rd]. Issue fire to x0 is accepted and changes nothing.
- Retire to rd!=0:
  - cnt>0: decrement.
  - cnt==0: counter stays 0 and error sets.
  - Retire to x0 is ignored.
- Issue fire and retire to the same register in the same cycle leave the count unchanged. This never causes an error, including at cnt==0.
- A FULL register with a same-cycle retire still has issue_ready=0; no bypass.
- FSM states:
  - RUN: normal issue. Goes to DRAIN when drain_req=1.
  - DRAIN: issue_ready=0; retires continue. Goes to IDLE on the edge where all registered counters are 0.
  - IDLE: issue_ready=0, drained=1. Goes to RUN when drain_req=0.
- drained is registered: it is 1 only in IDLE.
- error stays set until rst.
- Reset values: all cnt=0, state=RUN, issue_ready follows from RUN, drained=0, error=0. All queried statuses read VALID.

## Timing

- Issue/retire to status latency: 1 cycle (visible the cycle after the edge).
- drain_req with an already-empty scoreboard: DRAIN for exactly 1 cycle, then IDLE. drained=1 on the 2nd cycle after drain_req is sampled.
- When the last retire occurs in cycle N, the counters are 0 in N+1 and the FSM is in IDLE in N+2.
- drain_req dropped while in DRAIN: the block still completes DRAIN->IDLE, then returns to RUN the cycle after. Drain is never aborted mid-way.
- rst asserted mid-operation: all state cleared on that edge regardless of issue/retire/drain inputs that cycle.

## Structure

- gecko package owns:
  - gecko_reg_status_t: 2-bit enum GECKO_REG_STATUS_VALID=0, GECKO_REG_STATUS_PARTIAL=1, GECKO_REG_STATUS_FULL=2.
  - the scoreboard FSM state enum: GECKO_SB_RUN, GECKO_SB_DRAIN, GECKO_SB_IDLE.
- Sub-module gecko_reg_counter: a single saturating up/down counter with inc, dec, count, status and underflow outputs, parameterised by MAX_INFLIGHT. It is instantiated 31 times by a generate loop.
- Top level holds the FSM, the all-zero reduction, issue_ready and the query muxes.

## Test plan

- Reset, then query x0..x31 -> all VALID; issue_ready=1, drained=0, error=0.
- With MAX_INFLIGHT=3, issue x5 three times -> x5 reads PARTIAL, PARTIAL, FULL on successive cycles; issue_ready=0 for issue_rd=5 and 1 for issue_rd=6.
- x5 FULL, issue x5 and retire x5 in the same cycle -> issue not accepted (ready=0); count becomes 2 (PARTIAL). Separately, with x7 at count 1, issue and retire x7 in the same cycle -> x7 stays PARTIAL.
- Retire x9 at count 0 -> error=1 and stays 1; x9 stays VALID. Issue and retire to x0 -> no status change, no error.
- x3=1 and x4=2 outstanding, pulse drain_req -> issue_ready=0 from the next cycle; retire x3, x4, x4 -> drained=1 two cycles after the last retire; drop drain_req -> RUN and issue_ready=1 one cycle later.
- Assert rst during DRAIN with x10 FULL -> next cycle: RUN, x10 VALID, drained=0, error=0.
